// File: rtl/mul_div_unit.sv
// Signed 32x32 multiply (radix-4 Booth) and divide (non-restoring) into a 64-bit Z result.
// Latency: MUL done 17 edges after capture, DIV 34, DIV by zero 1.
// Backpressure: none; start is accepted only in IDLE and ignored while an operation runs.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int AW       = WIDTH + 2;
    localparam int CW       = $clog2(WIDTH + 1);
    localparam int MUL_ITER = WIDTH / 2;
    localparam int DIV_ITER = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic            op_q;
    logic            dz_q;
    logic            neg_q;
    logic            neg_a_q;
    logic            prev_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [WIDTH-1:0] m_q;

    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    d_ext;
    logic [AW-1:0]    booth_add;
    logic [AW-1:0]    mul_sum;
    logic [AW-1:0]    div_shift;
    logic [AW-1:0]    div_new;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             iterate;

    assign m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    assign d_ext = {2'b00, m_q};

    always_comb begin
        booth_add = '0;
        case ({mq_q[1:0], prev_q})
            3'b001, 3'b010: booth_add = m_ext;
            3'b011:         booth_add = m_ext << 1;
            3'b100:         booth_add = -(m_ext << 1);
            3'b101, 3'b110: booth_add = -m_ext;
            default:        booth_add = '0;
        endcase
    end

    assign mul_sum   = acc_q + booth_add;
    assign div_shift = {acc_q[AW-2:0], mq_q[WIDTH-1]};
    assign div_new   = acc_q[AW-1] ? (div_shift + d_ext) : (div_shift - d_ext);

    // Remainder fits in WIDTH bits once corrected, so the fix-up is done modulo 2^WIDTH.
    assign rem_fix = acc_q[WIDTH-1:0] + (acc_q[AW-1] ? m_q : '0);
    assign q_out   = neg_q   ? -mq_q    : mq_q;
    assign r_out   = neg_a_q ? -rem_fix : rem_fix;

    assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        iterate = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (op_q && dz_q) begin
                    state_d = DONE;
                end else if (!op_q && cnt_q == CW'(MUL_ITER)) begin
                    state_d = DONE;
                end else if (op_q && cnt_q == CW'(DIV_ITER)) begin
                    state_d = FIX;
                end else begin
                    iterate = 1'b1;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q        <= 1'b0;
            dz_q        <= 1'b0;
            neg_q       <= 1'b0;
            neg_a_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            m_q         <= '0;
            z_hi        <= '0;
            z_lo        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q        <= op;
                dz_q        <= op && (operand_b == '0);
                neg_q       <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                neg_a_q     <= operand_a[WIDTH-1];
                prev_q      <= 1'b0;
                cnt_q       <= '0;
                acc_q       <= '0;
                div_by_zero <= 1'b0;
                if (op) begin
                    // A zero divisor keeps the raw dividend so it can be returned in z_hi.
                    mq_q <= (operand_b == '0) ? operand_a : a_mag;
                    m_q  <= b_mag;
                end else begin
                    mq_q <= operand_b;
                    m_q  <= operand_a;
                end
            end
            if (iterate) begin
                cnt_q <= cnt_q + 1'b1;
                if (op_q) begin
                    acc_q <= div_new;
                    mq_q  <= {mq_q[WIDTH-2:0], ~div_new[AW-1]};
                end else begin
                    acc_q  <= {{2{mul_sum[AW-1]}}, mul_sum[AW-1:2]};
                    mq_q   <= {mul_sum[1:0], mq_q[WIDTH-1:2]};
                    prev_q <= mq_q[1];
                end
            end
            if (state_q == RUN && state_d == DONE) begin
                if (op_q) begin
                    z_hi        <= mq_q;
                    z_lo        <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    z_hi <= acc_q[WIDTH-1:0];
                    z_lo <= mq_q;
                end
            end
            if (state_q == FIX) begin
                z_hi <= r_out;
                z_lo <= q_out;
            end
        end
    end

    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, randomized ops against a 64-bit arithmetic
// reference, and hand-written sequences for start-while-busy and mid-operation clear.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          inj;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic; SV division truncates toward zero.
    task automatic model(input logic mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        int     sa;
        int     sb;
        longint p;
        longint q;
        longint r;
        sa  = a;
        sb  = b;
        dbz = 1'b0;
        if (!mop) begin
            p  = longint'(sa) * longint'(sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else begin
            q  = longint'(sa) / longint'(sb);
            r  = longint'(sa) % longint'(sb);
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    function automatic int exp_lat(input logic mop, input logic [31:0] b);
        if (!mop) return 17;
        if (b == 32'd0) return 1;
        return 34;
    endfunction

    task automatic do_op(input logic mop, input logic [31:0] a, input logic [31:0] b, input int inj,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                         output logic dbz0, output int lat, output int busy_cyc,
                         output logic stable, output logic idle_ok);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        @(negedge clock);
        prev_hi   = z_hi;
        prev_lo   = z_lo;
        start     = 1'b1;
        op        = mop;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        op        = 1'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        lat       = 0;
        dbz0      = div_by_zero;
        busy_cyc  = busy ? 1 : 0;
        stable    = (z_hi == prev_hi) && (z_lo == prev_lo);
        while (!done && lat < 200) begin
            if (lat + 1 == inj) begin
                start     = 1'b1;
                op        = 1'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
            if (!done && (z_hi != prev_hi || z_lo != prev_lo)) stable = 1'b0;
            if (busy) busy_cyc++;
        end
        hi  = z_hi;
        lo  = z_lo;
        dbz = div_by_zero;
        // A start raised during DONE must not launch a new operation.
        start     = 1'b1;
        op        = 1'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        @(posedge clock);
        #1;
        start   = 1'b0;
        idle_ok = !busy && !done && (z_hi == hi) && (z_lo == lo);
    endtask

    task automatic run_check(input string name, input logic mop, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                             input logic edbz, input int inj);
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        dbz0;
        int          lat;
        int          bc;
        logic        stable;
        logic        idle_ok;
        do_op(mop, a, b, inj, hi, lo, dbz, dbz0, lat, bc, stable, idle_ok);
        check({name, "_z"}, {hi, lo}, {ehi, elo});
        check({name, "_dbz"}, 64'(dbz), 64'(edbz));
        check({name, "_dbz_cleared"}, 64'(dbz0), 64'd0);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat(mop, b)));
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat(mop, b)));
        check({name, "_z_held"}, 64'(stable), 64'd1);
        check({name, "_idle_after"}, 64'(idle_ok), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
        logic        rop;

        vecs.push_back('{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5});
        vecs.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 7});
        vecs.push_back('{1'b1, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 0});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0});
        vecs.push_back('{1'b1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0});
        vecs.push_back('{1'b0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 0});

        clear     = 1'b0;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        #1;
        check("reset_z", {z_hi, z_lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b1;

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].inj);
        end

        for (int n = 0; n < 30; n++) begin
            rop = 1'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, edbz);
            run_check($sformatf("rand%0d", n), rop, ra, rb, ehi, elo, edbz,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
        end

        // Clear in the middle of a divide must zero everything without a clock edge.
        run_check("pre_clear", 1'b0, 32'd1234, 32'd5678, 32'd0, 32'd7006652, 1'b0, 0);
        @(negedge clock);
        start     = 1'b1;
        op        = 1'b1;
        operand_a = 32'd1000;
        operand_b = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("clear_z", {z_hi, z_lo}, 64'd0);
        check("clear_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        run_check("post_clear", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
